// File: rtl/ofifo_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ofifo_multi
// Description : Multi-column output FIFO that collects per-column psums and
//               pops whole aligned rows. Optional macro OFIFO_ERR_EN enables a
//               sticky overflow/underflow error flag on o_err.
// Revision    : 1.0 - initial release
// ============================================================================
module ofifo_multi #(
    parameter int col       = 8,
    parameter int bw        = 16,
    parameter int depth     = 64,
    parameter int AF_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col*bw-1:0]        in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [col*bw-1:0]        out,
    output logic                     o_full,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic                     o_almost_full,
    output logic [$clog2(depth):0]   o_count,
    output logic                     o_err
);

    localparam int              c_AW       = $clog2(depth);
    localparam int              c_PW       = c_AW + 1;
    localparam logic [c_PW-1:0] c_ONE      = c_PW'(1);
    localparam logic [c_PW-1:0] c_AF_LEVEL = c_PW'(depth - AF_MARGIN);

    logic [col-1:0]           w_full;
    logic [col-1:0]           w_empty;
    logic [col-1:0]           w_af;
    logic [col-1:0][c_PW-1:0] w_occ;
    logic [c_PW-1:0]          w_min;
    logic                     w_rd_acc;

    assign o_full        = |w_full;
    assign o_ready       = ~o_full;
    assign o_valid       = ~|w_empty;
    assign o_almost_full = |w_af;
    assign o_count       = w_min;
    assign w_rd_acc      = rd & o_valid;

    for (genvar c = 0; c < col; c++) begin : g_col
        logic [bw-1:0]   r_mem [depth];
        logic [c_PW-1:0] r_wr_ptr;
        logic [c_PW-1:0] r_rd_ptr;
        logic [bw-1:0]   r_out;
        logic            w_wr_ok;

        // Extra MSB on each pointer distinguishes full from empty.
        assign w_full[c]  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                            (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
        assign w_empty[c] = (r_wr_ptr == r_rd_ptr);
        assign w_occ[c]   = r_wr_ptr - r_rd_ptr;
        assign w_af[c]    = (w_occ[c] >= c_AF_LEVEL);
        assign w_wr_ok    = wr[c] & ~w_full[c];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_out    <= '0;
            end else begin
                if (w_wr_ok) begin
                    r_wr_ptr <= r_wr_ptr + c_ONE;
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= r_rd_ptr + c_ONE;
                    r_out    <= r_mem[r_rd_ptr[c_AW-1:0]];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset && w_wr_ok) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= in[c*bw +: bw];
            end
        end

        assign out[c*bw +: bw] = r_out;
    end

    // Poppable rows are limited by the least-filled column.
    always_comb begin
        w_min = w_occ[0];
        for (int i = 1; i < col; i++) begin
            if (w_occ[i] < w_min) begin
                w_min = w_occ[i];
            end
        end
    end

`ifdef OFIFO_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((|(wr & w_full)) || (rd && !o_valid)) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule
`default_nettype wire
